// File: rtl/m_serializer.sv
// Parallel-in/serial-out transmitter: first bit on s_out one cycle after the transfer edge.
// Backpressure: ready_out only in IDLE or the final clk of a frame, so words chain with no gap.
module m_serializer #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter bit MSB_FIRST    = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             s_out,
  output logic             s_valid,
  output logic             s_strobe,
  output logic             frame_start,
  output logic             done
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);

  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("m_serializer: WIDTH must be >= 2");
    end
    if (CLKS_PER_BIT < 1) begin : g_bad_cpb
      $error("m_serializer: CLKS_PER_BIT must be >= 1");
    end
  endgenerate

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]    clk_cnt_q, clk_cnt_d;
  logic             in_shift, strobe, last_cyc, xfer;
  logic [WIDTH-1:0] sreg_shifted;

  assign in_shift  = (state_q == SHIFT);
  assign strobe    = in_shift & (clk_cnt_q == CLK_LAST);
  assign last_cyc  = strobe & (bit_cnt_q == BIT_LAST);
  assign ready_out = ~in_shift | last_cyc;
  assign xfer      = valid_in & ready_out;

  // Shift toward whichever end feeds s_out, zero filling behind.
  assign sreg_shifted = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      bit_cnt_q <= '0;
      clk_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      bit_cnt_q <= bit_cnt_d;
      clk_cnt_q <= clk_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    bit_cnt_d = bit_cnt_q;
    clk_cnt_d = clk_cnt_q;
    if (xfer) begin
      state_d   = SHIFT;
      sreg_d    = data_in;
      bit_cnt_d = '0;
      clk_cnt_d = '0;
    end else if (in_shift) begin
      if (last_cyc) begin
        state_d   = IDLE;
        sreg_d    = '0;
        bit_cnt_d = '0;
        clk_cnt_d = '0;
      end else if (strobe) begin
        sreg_d    = sreg_shifted;
        bit_cnt_d = bit_cnt_q + 1'b1;
        clk_cnt_d = '0;
      end else begin
        clk_cnt_d = clk_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    s_valid     = in_shift;
    s_out       = in_shift & (MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0]);
    s_strobe    = strobe;
    done        = last_cyc;
    frame_start = in_shift & (bit_cnt_q == '0) & (clk_cnt_q == '0);
  end

endmodule

// File: tb/tb_m_serializer.sv
// Bench for m_serializer: five configurations share clk/rst, each with a receiver model and scoreboard.
module tb_m_serializer;

  localparam int NI = 5;
  localparam int CPB_T [NI] = '{1, 4, 1, 3, 3};
  localparam bit MSB_T [NI] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  logic       clk;
  logic       rst;
  logic [7:0] din [NI];
  logic       vin [NI];
  logic       rdy [NI];
  logic       so  [NI];
  logic       sv  [NI];
  logic       ss  [NI];
  logic       fs  [NI];
  logic       dn  [NI];

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] exp_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  for (genvar g = 0; g < NI; g++) begin : g_inst
    logic [7:0] rx;
    logic [7:0] rx_upd;
    int         vcnt;
    int         vcnt_upd;

    m_serializer #(.WIDTH(8), .CLKS_PER_BIT(CPB_T[g]), .MSB_FIRST(MSB_T[g])) u_dut (
      .clk        (clk),
      .rst        (rst),
      .data_in    (din[g]),
      .valid_in   (vin[g]),
      .ready_out  (rdy[g]),
      .s_out      (so[g]),
      .s_valid    (sv[g]),
      .s_strobe   (ss[g]),
      .frame_start(fs[g]),
      .done       (dn[g])
    );

    // Receiver shift register clocked by s_strobe, shifting in from the opposite end.
    always_comb begin
      rx_upd   = rx;
      vcnt_upd = vcnt + (sv[g] ? 1 : 0);
      if (ss[g]) rx_upd = MSB_T[g] ? {rx[6:0], so[g]} : {so[g], rx[7:1]};
    end

    always @(negedge clk or posedge rst) begin
      if (rst) begin
        rx   <= '0;
        vcnt <= 0;
      end else begin
        rx   <= rx_upd;
        vcnt <= dn[g] ? 0 : vcnt_upd;
        if (dn[g]) begin
          chk("word_pending_at_done", (exp_q.size() != 0), 1);
          if (exp_q.size() != 0) chk("rx_word", rx_upd, exp_q.pop_front());
          chk("valid_cycles_per_frame", vcnt_upd, 8 * CPB_T[g]);
        end
      end
    end
  end

  // Call at a negedge; returns at the negedge of bit-period cycle 1.
  task automatic send(input int s, input logic [7:0] w);
    chk("ready_before_send", rdy[s], 1);
    din[s] = w;
    vin[s] = 1'b1;
    exp_q.push_back(w);
    @(posedge clk);
    @(negedge clk);
    vin[s] = 1'b0;
  endtask

  task automatic wait_done(input int s);
    int n = 0;
    while (!dn[s] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("done_within_budget", (n < 200), 1);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] w;
    int s;
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      din[i] = '0;
      vin[i] = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    chk("rst_s_valid", sv[0], 0);
    chk("rst_s_out", so[0], 0);
    chk("rst_s_strobe", ss[0], 0);
    chk("rst_frame_start", fs[0], 0);
    chk("rst_done", dn[0], 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", rdy[0], 1);
    chk("idle_s_valid", sv[0], 0);

    // Single frame, MSB first, one clk per bit.
    w = 8'hA5;
    send(0, w);
    for (int k = 1; k <= 8; k++) begin
      chk("a5_s_out", so[0], w[8-k]);
      chk("a5_s_valid", sv[0], 1);
      chk("a5_strobe", ss[0], 1);
      chk("a5_done", dn[0], (k == 8));
      chk("a5_frame_start", fs[0], (k == 1));
      @(negedge clk);
    end
    chk("a5_ready_after", rdy[0], 1);
    chk("a5_idle_s_valid", sv[0], 0);

    // Back-to-back: valid held high across the frame boundary.
    chk("b2b_ready", rdy[0], 1);
    din[0] = 8'h3C;
    vin[0] = 1'b1;
    exp_q.push_back(8'h3C);
    @(posedge clk);
    @(negedge clk);
    din[0] = 8'hC3;
    exp_q.push_back(8'hC3);
    for (int k = 1; k <= 16; k++) begin
      if (k == 9) vin[0] = 1'b0;
      chk("b2b_s_valid", sv[0], 1);
      chk("b2b_frame_start", fs[0], (k == 1 || k == 9));
      chk("b2b_done", dn[0], (k == 8 || k == 16));
      chk("b2b_ready", rdy[0], (k == 8 || k == 16));
      @(negedge clk);
    end
    chk("b2b_idle_after", sv[0], 0);

    // Four clks per bit, LSB first.
    w = 8'h01;
    send(1, w);
    chk("cpb4_first_bit", so[1], 1);
    for (int k = 1; k <= 32; k++) begin
      chk("cpb4_s_out", so[1], w[(k-1)/4]);
      chk("cpb4_strobe", ss[1], (k % 4 == 0));
      chk("cpb4_done", dn[1], (k == 32));
      @(negedge clk);
    end
    chk("cpb4_idle_after", sv[1], 0);

    // Reset asserted mid-frame during bit 3.
    send(0, 8'hFF);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("abort_pre_s_out", so[0], 1);
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    chk("abort_s_valid", sv[0], 0);
    chk("abort_s_out", so[0], 0);
    chk("abort_done", dn[0], 0);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready_after", rdy[0], 1);
    chk("abort_idle", sv[0], 0);
    send(0, 8'h81);
    wait_done(0);
    chk("abort_queue_drained", exp_q.size(), 0);

    // valid_in toggling and data_in changing mid-frame must not disturb the word.
    send(0, 8'h5A);
    for (int k = 1; k <= 8; k++) begin
      if (k < 8) chk("midframe_ready_low", rdy[0], 0);
      vin[0] = (k < 8) ? k[0] : 1'b0;
      din[0] = 8'($urandom);
      @(negedge clk);
    end
    chk("midframe_no_extra_xfer", sv[0], 0);
    chk("midframe_queue_drained", exp_q.size(), 0);

    // Random frames across configurations.
    for (int i = 0; i < 1000; i++) begin
      case (i % 4)
        0:       s = 0;
        1:       s = 2;
        2:       s = 3;
        default: s = 4;
      endcase
      send(s, 8'($urandom));
      wait_done(s);
    end
    chk("random_queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
